// File: rtl/sr_bank_pkg.sv
// sr_bank_pkg: opcodes, FSM state encoding and width helper for the SR bank controller
package sr_bank_pkg;
  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_SET = 2'b01;
  localparam logic [1:0] OP_CLR = 2'b10;
  localparam logic [1:0] OP_TOG = 2'b11;
  typedef enum logic [1:0] {IDLE = 2'd0, DRIVE = 2'd1, SETTLE = 2'd2} state_t;
  function automatic int clog2_min1(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sr_bank_ctrl_rr_arbiter.sv
// rr_arbiter: round-robin grant; priority rotates to the requester after each winner
module rr_arbiter import sr_bank_pkg::*; #(
  parameter int N_REQ = 4,
  localparam int IW = clog2_min1(N_REQ)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             en,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    grant_idx
);
  logic [IW-1:0] ptr;
  logic found;
  int j;
  always_comb begin
    grant = '0;
    grant_idx = '0;
    found = 1'b0;
    j = 0;
    for (int k = 0; k < N_REQ; k++) begin
      j = (int'(ptr) + k) % N_REQ;
      if (en && !found && req[j]) begin
        found = 1'b1;
        grant[j] = 1'b1;
        grant_idx = IW'(j);
      end
    end
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) ptr <= '0;
    else if (|grant) ptr <= (int'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + 1'b1;
endmodule

// File: rtl/sr_bank_ctrl.sv
// sr_bank_ctrl: arbitrates requester SET/CLR/TOGGLE commands onto an SR bit bank
// with a one-cycle drive pulse, a settle window and a shadow copy of the bank.
module sr_bank_ctrl import sr_bank_pkg::*; #(
  parameter int N_REQ = 4,
  parameter int N_BITS = 8,
  parameter int SETTLE_CYC = 1,
  localparam int AW = clog2_min1(N_BITS),
  localparam int IW = clog2_min1(N_REQ)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [2*N_REQ-1:0]  req_op,
  input  logic [N_REQ*AW-1:0] req_addr,
  input  logic                bank_clear,
  output logic [N_REQ-1:0]    req_ready,
  output logic [IW-1:0]       grant_id,
  output logic [N_BITS-1:0]   sr_set,
  output logic [N_BITS-1:0]   sr_rst,
  output logic [N_BITS-1:0]   bank_q,
  output logic                busy,
  output logic                err
);
  state_t state, state_n;
  logic pend, do_clr, arb_en, accept, in_rng, do_drive;
  logic [3:0] cnt;
  logic [N_REQ-1:0] gnt;
  logic [IW-1:0] gidx;
  logic [1:0] op;
  logic [AW-1:0] addr;
  logic [N_BITS-1:0] sel, drv_set, drv_rst;
  // a clear (live or pending) pre-empts every requester while idle
  assign do_clr = !reset && state == IDLE && (bank_clear || pend);
  assign arb_en = !reset && state == IDLE && !bank_clear && !pend;
  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clock(clock),
    .reset(reset),
    .req(req_valid),
    .en(arb_en),
    .grant(gnt),
    .grant_idx(gidx)
  );
  always_comb begin
    accept = |gnt;
    op = req_op[2*int'(gidx) +: 2];
    addr = req_addr[AW*int'(gidx) +: AW];
    in_rng = int'(addr) < N_BITS;
    sel = N_BITS'(1) << addr;
    drv_set = do_clr ? '0 :
              (accept && (op == OP_SET || (op == OP_TOG && !(|(bank_q & sel))))) ? sel : '0;
    drv_rst = do_clr ? '1 :
              (accept && (op == OP_CLR || (op == OP_TOG && |(bank_q & sel)))) ? sel : '0;
    do_drive = do_clr || (accept && op != OP_NOP && in_rng);
    state_n = state == IDLE  ? (do_drive ? DRIVE : IDLE) :
              state == DRIVE ? SETTLE :
              (cnt == 4'(SETTLE_CYC - 1) ? IDLE : SETTLE);
  end
  assign req_ready = gnt;
  assign err = accept && !in_rng;
  assign busy = state != IDLE;
  // drive regs are async-reset flops so a mid-DRIVE reset drops them at once
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      pend <= 1'b0;
      cnt <= '0;
      grant_id <= '0;
      sr_set <= '0;
      sr_rst <= '0;
      bank_q <= '0;
    end else begin
      state <= state_n;
      pend <= state != IDLE && (pend || bank_clear);
      cnt <= state == SETTLE ? cnt + 4'd1 : 4'd0;
      grant_id <= accept ? gidx : grant_id;
      sr_set <= do_drive ? drv_set : '0;
      sr_rst <= do_drive ? drv_rst : '0;
      bank_q <= state == DRIVE ? (bank_q | sr_set) & ~sr_rst : bank_q;
    end
endmodule

// File: tb/tb_sr_bank_ctrl.sv
// tb_sr_bank_ctrl: scenario tasks plus randomized traffic against a spec-level bank model
module tb_sr_bank_ctrl;
  logic clock = 1'b0, reset = 1'b1;
  always #5 clock = ~clock;
  logic [3:0] valid, rdy;
  logic [7:0] op, sset, srst, bq;
  logic [11:0] addr;
  logic [1:0] gid;
  logic clr, busy, err;
  logic [3:0] v6, rdy6;
  logic [7:0] op6;
  logic [11:0] a6;
  logic [1:0] gid6;
  logic [5:0] sset6, srst6, bq6;
  logic clr6, busy6, err6;
  int total = 0, bad = 0;
  int m_ptr;
  logic [7:0] m_bank;

  sr_bank_ctrl dut (
    .clock(clock), .reset(reset), .req_valid(valid), .req_op(op), .req_addr(addr),
    .bank_clear(clr), .req_ready(rdy), .grant_id(gid), .sr_set(sset), .sr_rst(srst),
    .bank_q(bq), .busy(busy), .err(err)
  );
  sr_bank_ctrl #(.N_BITS(6), .SETTLE_CYC(3)) dut6 (
    .clock(clock), .reset(reset), .req_valid(v6), .req_op(op6), .req_addr(a6),
    .bank_clear(clr6), .req_ready(rdy6), .grant_id(gid6), .sr_set(sset6), .sr_rst(srst6),
    .bank_q(bq6), .busy(busy6), .err(err6)
  );

  task automatic do_reset();
    reset = 1'b1; valid = '0; clr = 1'b0; v6 = '0; clr6 = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    m_bank = '0; m_ptr = 0;
  endtask

  task automatic issue(input int r, input logic [1:0] o, input logic [2:0] a);
    int n = 0;
    valid[r] = 1'b1; op[2*r +: 2] = o; addr[3*r +: 3] = a;
    @(negedge clock);
    while (!rdy[r] && n < 20) begin @(negedge clock); n++; end
    total++;
    if (!rdy[r]) begin bad++; $display("FAIL issue_timeout req=%0d ready=%b", r, rdy); end
    @(posedge clock);
    #1 valid[r] = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; valid = 4'hF; op = 8'h55; addr = 12'h688; clr = 1'b1; v6 = 4'hF; op6 = 8'h55; a6 = 12'h688; clr6 = 1'b0;
    @(negedge clock);
    total++; if (rdy !== 4'h0) begin bad++; $display("FAIL reset_ready got=%b want=0000", rdy); end
    total++; if (gid !== 2'd0) begin bad++; $display("FAIL reset_grant_id got=%0d want=0", gid); end
    total++; if ({sset, srst, bq} !== 24'h0) begin bad++; $display("FAIL reset_drive_bank got=%h/%h/%h want=0", sset, srst, bq); end
    total++; if ({busy, err} !== 2'b00) begin bad++; $display("FAIL reset_busy_err got=%b%b want=00", busy, err); end
    total++; if (rdy6 !== 4'h0) begin bad++; $display("FAIL reset_ready6 got=%b want=0000", rdy6); end
    clr = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    valid[0] = 1'b1; op[1:0] = 2'b01; addr[2:0] = 3'd3;
    @(negedge clock);
    total++; if (rdy !== 4'b0001) begin bad++; $display("FAIL single_ready got=%b want=0001", rdy); end
    @(posedge clock); #1 valid = '0;
    @(negedge clock);
    total++; if (sset !== 8'h08 || srst !== 8'h00) begin bad++; $display("FAIL single_drive got=%h/%h want=08/00", sset, srst); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy_drive got=%b want=1", busy); end
    @(negedge clock);
    total++; if (sset !== 8'h00 || bq !== 8'h08) begin bad++; $display("FAIL single_bank got=%h/%h want=00/08", sset, bq); end
    @(negedge clock);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle got=%b want=0", busy); end
  endtask

  task automatic test_rr();
    int ord[$], tg[$];
    do_reset();
    valid = 4'hF; op = 8'h55; addr = {3'd3, 3'd2, 3'd1, 3'd0};
    for (int c = 0; c < 30 && ord.size() < 4; c++) begin
      @(negedge clock);
      if (|rdy) begin
        for (int k = 0; k < 4; k++) if (rdy[k]) begin ord.push_back(k); tg.push_back(c); end
        @(posedge clock); #1 valid = valid & ~rdy;
      end
    end
    total++; if (ord.size() != 4) begin bad++; $display("FAIL rr_count got=%0d want=4", ord.size()); end
    for (int k = 0; k < ord.size(); k++) begin
      total++; if (ord[k] != k) begin bad++; $display("FAIL rr_order slot=%0d got=%0d want=%0d", k, ord[k], k); end
      if (k > 0) begin
        total++; if (tg[k] - tg[k-1] != 3) begin bad++; $display("FAIL rr_gap slot=%0d got=%0d want=3", k, tg[k] - tg[k-1]); end
      end
    end
    @(negedge clock); @(negedge clock);
    total++; if (bq !== 8'h0F) begin bad++; $display("FAIL rr_bank got=%h want=0f", bq); end
  endtask

  task automatic test_toggle();
    do_reset();
    issue(2, 2'b01, 3'd2);
    issue(2, 2'b11, 3'd2);
    @(negedge clock);
    total++; if (srst !== 8'h04 || sset !== 8'h00) begin bad++; $display("FAIL tog1_drive got=%h/%h want=04/00", srst, sset); end
    @(negedge clock);
    total++; if (bq !== 8'h00) begin bad++; $display("FAIL tog1_bank got=%h want=00", bq); end
    issue(3, 2'b11, 3'd2);
    @(negedge clock);
    total++; if (sset !== 8'h04 || srst !== 8'h00) begin bad++; $display("FAIL tog2_drive got=%h/%h want=04/00", sset, srst); end
    @(negedge clock);
    total++; if (bq !== 8'h04) begin bad++; $display("FAIL tog2_bank got=%h want=04", bq); end
  endtask

  task automatic test_clear();
    do_reset();
    issue(0, 2'b01, 3'd5);
    valid[1] = 1'b1; op[3:2] = 2'b01; addr[5:3] = 3'd1;
    @(posedge clock); #1 clr = 1'b1;
    @(negedge clock);
    total++; if (rdy !== 4'h0 || bq !== 8'h20) begin bad++; $display("FAIL clr_settle got=%b/%h want=0000/20", rdy, bq); end
    @(posedge clock); #1 clr = 1'b0;
    @(negedge clock);
    total++; if (rdy !== 4'h0) begin bad++; $display("FAIL clr_pending_ready got=%b want=0000", rdy); end
    @(negedge clock);
    total++; if (srst !== 8'hFF || sset !== 8'h00) begin bad++; $display("FAIL clr_drive got=%h/%h want=ff/00", srst, sset); end
    @(negedge clock);
    total++; if (bq !== 8'h00) begin bad++; $display("FAIL clr_bank got=%h want=00", bq); end
    @(negedge clock);
    total++; if (rdy !== 4'b0010) begin bad++; $display("FAIL clr_then_req1 got=%b want=0010", rdy); end
    @(posedge clock); #1 valid = '0;
    @(negedge clock);
    total++; if (sset !== 8'h02) begin bad++; $display("FAIL clr_req1_drive got=%h want=02", sset); end
    @(negedge clock);
    total++; if (bq !== 8'h02) begin bad++; $display("FAIL clr_req1_bank got=%h want=02", bq); end
  endtask

  task automatic test_settle_err();
    int t0 = -1, t1 = -1;
    logic [3:0] g;
    do_reset();
    v6 = 4'b0011; op6 = 8'h55; a6 = 12'b000_000_001_000;
    for (int c = 0; c < 16; c++) begin
      @(negedge clock);
      g = rdy6;
      if (g[0]) t0 = c;
      if (g[1]) t1 = c;
      @(posedge clock); #1 v6 = v6 & ~g;
    end
    total++; if (t0 != 0 || t1 - t0 != 5) begin bad++; $display("FAIL settle3_gap got=%0d,%0d want=0,5", t0, t1); end
    total++; if (bq6 !== 6'h03) begin bad++; $display("FAIL settle3_bank got=%h want=03", bq6); end
    v6 = 4'b0100; a6[8:6] = 3'd7;
    @(negedge clock);
    total++; if (rdy6 !== 4'b0100 || err6 !== 1'b1) begin bad++; $display("FAIL err_accept got=%b/%b want=0100/1", rdy6, err6); end
    @(posedge clock); #1 v6 = '0;
    @(negedge clock);
    total++; if ({sset6, srst6} !== 12'h0 || busy6 !== 1'b0 || err6 !== 1'b0) begin bad++; $display("FAIL err_nodrive got=%h/%h/%b/%b want=0/0/0/0", sset6, srst6, busy6, err6); end
    total++; if (bq6 !== 6'h03) begin bad++; $display("FAIL err_bank got=%h want=03", bq6); end
  endtask

  task automatic test_reset_drive();
    do_reset();
    issue(0, 2'b01, 3'd6);
    issue(1, 2'b01, 3'd4);
    #1;
    total++; if (sset !== 8'h10 || bq !== 8'h40) begin bad++; $display("FAIL rstdrv_pre got=%h/%h want=10/40", sset, bq); end
    reset = 1'b1;
    #1;
    total++; if ({sset, srst, bq} !== 24'h0) begin bad++; $display("FAIL rstdrv_async got=%h/%h/%h want=0", sset, srst, bq); end
    valid = 4'hF; op = 8'h55; addr = 12'h0;
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    total++; if (rdy !== 4'b0001) begin bad++; $display("FAIL rstdrv_first_grant got=%b want=0001", rdy); end
    @(posedge clock); #1 valid = '0;
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic test_random();
    int n, w;
    logic [3:0] mask;
    logic [1:0] o;
    logic [2:0] a;
    logic [7:0] es, er, bit_m;
    do_reset();
    for (int it = 0; it < 40; it++) begin
      @(posedge clock); #1;
      mask = 4'($urandom_range(1, 15));
      for (int i = 0; i < 4; i++) begin op[2*i +: 2] = 2'($urandom_range(0, 3)); addr[3*i +: 3] = 3'($urandom_range(0, 7)); end
      valid = mask;
      w = -1;
      for (int k = 0; k < 4; k++) if (w < 0 && mask[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
      n = 0;
      @(negedge clock);
      while (rdy == 4'h0 && n < 20) begin @(negedge clock); n++; end
      total++; if (rdy !== 4'(1 << w)) begin bad++; $display("FAIL rand_grant it=%0d got=%b want=%b", it, rdy, 4'(1 << w)); end
      o = op[2*w +: 2]; a = addr[3*w +: 3];
      bit_m = 8'(1) << a;
      es = (o == 2'b01 || (o == 2'b11 && (m_bank & bit_m) == 0)) ? bit_m : 8'h0;
      er = (o == 2'b10 || (o == 2'b11 && (m_bank & bit_m) != 0)) ? bit_m : 8'h0;
      @(posedge clock); #1 valid = '0;
      @(negedge clock);
      total++; if (sset !== es || srst !== er || gid !== 2'(w)) begin bad++; $display("FAIL rand_drive it=%0d got=%h/%h/%0d want=%h/%h/%0d", it, sset, srst, gid, es, er, w); end
      m_bank = (m_bank | es) & ~er;
      m_ptr = (w + 1) % 4;
      @(negedge clock);
      total++; if (bq !== m_bank) begin bad++; $display("FAIL rand_bank it=%0d got=%h want=%h", it, bq, m_bank); end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_rr();
    test_toggle();
    test_clear();
    test_settle_err();
    test_reset_drive();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
